// File: rtl/lcd_scan_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : lcd_scan_ctrl
// Function : Panel power sequencing and frame-aligned pixel-source selection
//            (8-bar test pattern or FIFO-buffered RGB565 stream).
// Revision : 1.0
// =============================================================================
module lcd_scan_ctrl #(
    parameter int          PWR_DLY    = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BAR_W      = 60,
    parameter logic [15:0] UF_COLOR   = 16'hF800
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        src_sel,
    input  logic        tim_de,
    input  logic        tim_hsync,
    input  logic        tim_vsync,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    input  logic        clr_uf,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [15:0] lcd_rgb,
    output logic        disp_on,
    output logic        bl_en,
    output logic        underflow,
    output logic [2:0]  state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_DLY - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_PWR_ON = 3'd1;
    localparam logic [2:0] S_SYNC   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_BL_OFF = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic          act_src_q, act_src_d;
    logic          vs_q;
    logic [9:0]    col_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic          underflow_q;
    logic          lcd_de_q, lcd_hsync_q, lcd_vsync_q;
    logic [15:0]   lcd_rgb_q, rgb_d;

    logic          w_fs, w_run, w_empty, w_pop_req, w_pop, w_push, w_uf_set;
    logic [9:0]    w_bar_idx;
    logic [2:0]    w_bar;
    logic [15:0]   w_pat;

    assign w_fs      = tim_vsync & ~vs_q;
    assign w_run     = (state_q == S_RUN);
    assign w_empty   = (count_q == '0);
    assign w_pop_req = w_run & act_src_q & tim_de;
    assign w_pop     = w_pop_req & ~w_empty;
    assign w_uf_set  = w_pop_req & w_empty;
    assign s_ready   = (state_q != S_OFF) && (count_q < DEPTH_C);
    assign w_push    = s_valid & s_ready;

    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = '0;
        act_src_d = act_src_q;
        case (state_q)
            S_OFF: begin
                if (enable) state_d = S_PWR_ON;
            end
            S_PWR_ON: begin
                if (!enable)                    state_d = S_OFF;
                else if (pwr_cnt_q == PWR_LAST) state_d = S_SYNC;
                else                            pwr_cnt_d = pwr_cnt_q + 1'b1;
            end
            S_SYNC: begin
                if (!enable) begin
                    state_d = S_OFF;
                end else if (w_fs) begin
                    state_d   = S_RUN;
                    act_src_d = src_sel;
                end
            end
            S_RUN: begin
                if (w_fs)    act_src_d = src_sel;
                if (!enable) state_d   = S_BL_OFF;
            end
            S_BL_OFF: begin
                // Enable is deliberately ignored here; the panel must reach OFF first.
                if (w_fs) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    assign w_bar_idx = col_q / 10'(BAR_W);
    assign w_bar     = (w_bar_idx > 10'd7) ? 3'd7 : w_bar_idx[2:0];
    assign w_pat     = {{5{w_bar[2]}}, {6{w_bar[1]}}, {5{w_bar[0]}}};

    always_comb begin
        rgb_d = '0;
        if (w_run && tim_de) begin
            if (act_src_q) rgb_d = w_empty ? UF_COLOR : mem_q[rd_ptr_q];
            else           rgb_d = w_pat;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_OFF;
            pwr_cnt_q   <= '0;
            act_src_q   <= 1'b0;
            vs_q        <= 1'b1;
            col_q       <= '0;
            underflow_q <= 1'b0;
            lcd_de_q    <= 1'b0;
            lcd_hsync_q <= 1'b1;
            lcd_vsync_q <= 1'b1;
            lcd_rgb_q   <= '0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            act_src_q   <= act_src_d;
            vs_q        <= tim_vsync;
            col_q       <= tim_de ? col_q + 10'd1 : 10'd0;
            if (w_uf_set)    underflow_q <= 1'b1;
            else if (clr_uf) underflow_q <= 1'b0;
            lcd_de_q    <= tim_de;
            lcd_hsync_q <= tim_hsync;
            lcd_vsync_q <= tim_vsync;
            lcd_rgb_q   <= rgb_d;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (state_q == S_OFF) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (w_push) mem_q[wr_ptr_q] <= s_data;
    end

    assign state     = state_q;
    assign disp_on   = (state_q != S_OFF);
    assign bl_en     = w_run;
    assign underflow = underflow_q;
    assign lcd_de    = lcd_de_q;
    assign lcd_hsync = lcd_hsync_q;
    assign lcd_vsync = lcd_vsync_q;
    assign lcd_rgb   = lcd_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_scan_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_lcd_scan_ctrl
// Function : Scoreboard bench for lcd_scan_ctrl (sequencing, pattern, stream).
// Revision : 1.0
// =============================================================================
module tb_lcd_scan_ctrl;

    logic        pclk = 1'b0;
    logic        rst, enable, src_sel, tim_de, tim_hsync, tim_vsync;
    logic        s_valid, clr_uf;
    logic [15:0] s_data;
    logic        s_ready, lcd_de, lcd_hsync, lcd_vsync, disp_on, bl_en, underflow;
    logic [15:0] lcd_rgb;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q  [$];
    logic [15:0] fifo_m [$];
    logic        m_on, m_run, m_src;
    int          col_m;

    lcd_scan_ctrl dut (
        .pclk      (pclk),
        .rst       (rst),
        .enable    (enable),
        .src_sel   (src_sel),
        .tim_de    (tim_de),
        .tim_hsync (tim_hsync),
        .tim_vsync (tim_vsync),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .clr_uf    (clr_uf),
        .lcd_de    (lcd_de),
        .lcd_hsync (lcd_hsync),
        .lcd_vsync (lcd_vsync),
        .lcd_rgb   (lcd_rgb),
        .disp_on   (disp_on),
        .bl_en     (bl_en),
        .underflow (underflow),
        .state     (state)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat_px(input int c);
        int b;
        b = c / 60;
        if (b > 7) b = 7;
        return {(b >= 4) ? 5'h1F : 5'h00,
                ((b % 4) >= 2) ? 6'h3F : 6'h00,
                ((b % 2) == 1) ? 5'h1F : 5'h00};
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One pixel clock of stimulus; expected pixel and FIFO contents tracked by the model.
    task automatic cyc(input logic de, input logic vld, input logic [15:0] d);
        logic        acc;
        logic [15:0] e;
        tim_de  = de;
        s_valid = vld;
        s_data  = d;
        acc = vld && m_on && (fifo_m.size() < 16);
        if (de) begin
            if (!m_run)                e = 16'h0000;
            else if (!m_src)           e = pat_px(col_m);
            else if (fifo_m.size() > 0) e = fifo_m.pop_front();
            else                       e = 16'hF800;
            exp_q.push_back(e);
            col_m++;
        end else begin
            col_m = 0;
        end
        if (acc) fifo_m.push_back(d);
        tick();
    endtask

    task automatic frame_start();
        tim_vsync = 1'b1;
        tim_hsync = 1'b0;
        tim_de    = 1'b0;
        s_valid   = 1'b0;
        col_m     = 0;
        tick();
        check_val("lcd_vsync_dly", lcd_vsync, 1);
        check_val("lcd_hsync_dly", lcd_hsync, 0);
        tim_vsync = 1'b0;
        tim_hsync = 1'b1;
    endtask

    always @(negedge pclk) begin
        if (rst && lcd_de) begin
            if (exp_q.size() == 0) check_val("sb_spurious_de", lcd_de, 0);
            else                   check_val("pixel", lcd_rgb, exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b0; src_sel = 1'b0; tim_de = 1'b0;
        tim_hsync = 1'b1; tim_vsync = 1'b0; s_valid = 1'b0; s_data = '0; clr_uf = 1'b0;
        m_on = 1'b0; m_run = 1'b0; m_src = 1'b0; col_m = 0;

        repeat (2) tick();
        check_val("rst_state", state, 0);
        check_val("rst_disp_on", disp_on, 0);
        check_val("rst_bl_en", bl_en, 0);
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_underflow", underflow, 0);
        check_val("rst_rgb", lcd_rgb, 0);
        check_val("rst_de", lcd_de, 0);
        check_val("rst_hsync", lcd_hsync, 1);
        check_val("rst_vsync", lcd_vsync, 1);

        rst = 1'b1;
        repeat (2) tick();
        check_val("idle_state", state, 0);

        // Power-up
        enable = 1'b1;
        tick();
        m_on = 1'b1;
        check_val("pwr_state", state, 1);
        check_val("pwr_disp_on", disp_on, 1);
        check_val("pwr_bl_en", bl_en, 0);
        repeat (3) tick();
        check_val("pwr_hold", state, 1);
        tick();
        check_val("sync_state", state, 2);
        check_val("sync_bl_en", bl_en, 0);
        frame_start();
        check_val("run_state", state, 3);
        check_val("run_bl_en", bl_en, 1);
        m_run = 1'b1; m_src = 1'b0;

        // Pattern line with FIFO prefill (17th word must be refused)
        for (int i = 0; i < 480; i++) begin
            if (i == 0)  check_val("s_ready_empty", s_ready, 1);
            if (i == 16) check_val("s_ready_full", s_ready, 0);
            cyc(1'b1, (i < 17), 16'h1234 + 16'(i));
        end
        cyc(1'b0, 1'b0, 16'h0);
        check_val("de_fall_rgb", lcd_rgb, 0);
        check_val("de_fall_de", lcd_de, 0);
        check_val("still_full", s_ready, 0);
        cyc(1'b0, 1'b0, 16'h0);

        // Switch to stream at frame boundary
        src_sel = 1'b1;
        frame_start();
        m_src = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            if (i == 0) check_val("s_ready_reassert", s_ready, 1);
        end
        cyc(1'b0, 1'b0, 16'h0);
        check_val("no_uf_yet", underflow, 0);

        // Underflow: 3 words, 5 DE cycles
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'hA000 + 16'(i));
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        check_val("uf_set", underflow, 1);
        clr_uf = 1'b1;
        cyc(1'b1, 1'b0, 16'h0);
        check_val("uf_set_beats_clr", underflow, 1);
        cyc(1'b0, 1'b0, 16'h0);
        check_val("uf_cleared", underflow, 0);
        clr_uf = 1'b0;

        // Shutdown with words still buffered
        cyc(1'b0, 1'b1, 16'hB000);
        cyc(1'b0, 1'b1, 16'hB001);
        enable = 1'b0;
        cyc(1'b0, 1'b0, 16'h0);
        check_val("bloff_bl_en", bl_en, 0);
        check_val("bloff_state", state, 4);
        check_val("bloff_disp_on", disp_on, 1);
        enable = 1'b1;
        cyc(1'b0, 1'b0, 16'h0);
        check_val("bloff_ignores_en", state, 4);
        enable = 1'b0;
        frame_start();
        check_val("off_state", state, 0);
        check_val("off_disp_on", disp_on, 0);
        check_val("off_s_ready", s_ready, 0);
        m_run = 1'b0; m_on = 1'b0;
        fifo_m.delete();
        tick();

        // Re-power: FIFO must have been flushed
        enable = 1'b1;
        repeat (5) tick();
        m_on = 1'b1;
        check_val("resync_state", state, 2);
        frame_start();
        m_run = 1'b1; m_src = 1'b1;
        check_val("rerun_state", state, 3);
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);

        // Asynchronous reset mid-cycle
        @(posedge pclk);
        #3;
        rst = 1'b0;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_disp_on", disp_on, 0);
        check_val("arst_s_ready", s_ready, 0);
        check_val("arst_underflow", underflow, 0);
        check_val("arst_hsync", lcd_hsync, 1);
        check_val("sb_leftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
